// File: rtl/instr_sequencer.sv
// Fetch/decode/sequencing stage: 8-entry instruction store, PC, and control-word issue with valid/ready.
// Optional `SINGLE_STEP_EN adds a `step` input that gates each advance to FETCH through a STALL state.
//
// state   | meaning
// IDLE    | waiting for start; store writable
// FETCH   | read store[pc], decode into the control-word register
// ISSUE   | control word valid, waiting for ready
// RESOLVE | branch/jump issued, waiting for flag_valid to pick the next pc
// HALT    | HALT opcode fetched; store writable, waits for start
// STALL   | single-step only: waiting for step before the next fetch
module instr_sequencer #(
  parameter int PC_W     = 3,
  parameter int START_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [15:0]     prog_data,
  input  logic            start,
  input  logic            ready,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic            flag_valid,
  input  logic            zero_flag,
  input  logic            neg_flag,
  input  logic [PC_W-1:0] jump_target,
  output logic            valid,
  output logic            MemoryBus,
  output logic            MemoryData,
  output logic            ReadWrite,
  output logic            MemoryWrite,
  output logic            ProgramReg,
  output logic            Jump,
  output logic            Branch,
  output logic [3:0]      FunctionSelect,
  output logic [2:0]      DataReg_A,
  output logic [2:0]      AdderssReg_A,
  output logic [2:0]      AddressReg_B,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_RESOLVE, S_HALT, S_STALL
  } state_e;

  state_e state_q, state_d, adv_state;

  logic [15:0]     store_q [2**PC_W];
  logic [15:0]     fetch_word;
  logic [2:0]      fop;
  logic            fetch_halt;
  logic [19:0]     cw_q, cw_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] ba_ext;
  logic            taken;
  logic            store_open;

  // cw layout: {MB, MD, RW, MW, PL, Jump, Branch, FS[3:0], DA, AA, BA}
  assign fetch_word = store_q[pc_q];
  assign fop        = fetch_word[15:13];
  assign fetch_halt = (fop == 3'b011) || (fop == 3'b101);
  assign store_open = (state_q == S_IDLE) || (state_q == S_HALT);
  assign ba_ext     = PC_W'($signed(cw_q[2:0]));
  assign taken      = cw_q[9] ? neg_flag : zero_flag;

  always_ff @(posedge clk) begin
    if (prog_we && store_open) store_q[prog_addr] <= prog_data;
  end

  always_comb begin : decode
    logic mb, md, rw, mw, pl, jmp, br;
    mb = 1'b0; md = 1'b0; rw = 1'b0; mw = 1'b0; pl = 1'b0; jmp = 1'b0; br = 1'b0;
    case (fop)
      3'b000:  rw = 1'b1;
      3'b001:  begin md = 1'b1; rw = 1'b1; end
      3'b010:  mw = 1'b1;
      3'b100:  begin mb = 1'b1; rw = 1'b1; end
      3'b110:  begin pl = 1'b1; br = fetch_word[9]; end
      3'b111:  begin pl = 1'b1; jmp = 1'b1; end
      default: ;
    endcase
    cw_d = {mb, md, rw, mw, pl, jmp, br, fetch_word[12:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : next_state
`ifdef SINGLE_STEP_EN
    adv_state = step ? S_FETCH : S_STALL;
`else
    adv_state = S_FETCH;
`endif
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_FETCH;
      S_FETCH:        state_d = fetch_halt ? S_HALT : S_ISSUE;
      S_ISSUE:        if (ready) state_d = cw_q[15] ? S_RESOLVE : adv_state;
      S_RESOLVE:      if (flag_valid) state_d = adv_state;
`ifdef SINGLE_STEP_EN
      S_STALL:        if (step) state_d = S_FETCH;
`endif
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin : datapath_next
    pc_d     = pc_q;
    halted_d = halted_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) begin
        pc_d     = PC_W'(START_PC);
        halted_d = 1'b0;
      end
      S_FETCH:   if (fetch_halt) halted_d = 1'b1;
      S_ISSUE:   if (ready && !cw_q[15]) pc_d = pc_q + PC_W'(1);
      S_RESOLVE: if (flag_valid) begin
        if (cw_q[14])   pc_d = jump_target;
        else if (taken) pc_d = pc_q + ba_ext;
        else            pc_d = pc_q + PC_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= PC_W'(START_PC);
      halted_q <= 1'b0;
      cw_q     <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      if (state_q == S_FETCH) cw_q <= cw_d;
    end
  end

  always_comb begin : outputs
    valid          = (state_q == S_ISSUE);
    MemoryBus      = cw_q[19];
    MemoryData     = cw_q[18];
    ReadWrite      = cw_q[17];
    MemoryWrite    = cw_q[16];
    ProgramReg     = cw_q[15];
    Jump           = cw_q[14];
    Branch         = cw_q[13];
    FunctionSelect = cw_q[12:9];
    DataReg_A      = cw_q[8:6];
    AdderssReg_A   = cw_q[5:3];
    AddressReg_B   = cw_q[2:0];
    pc             = pc_q;
    halted         = halted_q;
  end

endmodule
